alu_shifter: RTL and testbench

ALU_SHIFTER -- requirements
Module: alu_shifter

---
 rtl/alu_shifter_if.sv | 28 ++
 rtl/alu_shifter.sv | 201 ++++++++++++++++++++
 tb/tb_alu_shifter.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/alu_shifter_if.sv
// Request/result bundle for the multi-cycle shifter/rotator.
// master drives the request side, slave (the shifter) drives status and results.
interface alu_shifter_if #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 8
);
  logic              start;
  logic [2:0]        op;
  logic [1:0]        size;
  logic [DATA_W-1:0] A;
  logic [CNT_W-1:0]  count;
  logic              cy_in;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] R;
  logic [5:0]        flags;
  logic [5:0]        flags_mask;

  modport master (
    output start, op, size, A, count, cy_in,
    input  busy, done, R, flags, flags_mask
  );

  modport slave (
    input  start, op, size, A, count, cy_in,
    output busy, done, R, flags, flags_mask
  );
endinterface

// File: rtl/alu_shifter.sv
// Multi-cycle shifter/rotator: one 1-bit step per clock on a byte/word/dword
// slice of A; bits above the slice pass through from A unchanged.
// flags = {Z,S,P,V,CY,AC}, bit 0 = AC (never updated).
// Optional build macro: ALU_SHIFT_COUNT_MASK_EN -- effective count is
// count[4:0]; otherwise the full count is iterated.
module alu_shifter #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 8
) (
  input  logic            clk,
  input  logic            reset_n,
  alu_shifter_if.slave    bus
);

  localparam int IDX_W = $clog2(DATA_W);

  localparam logic [2:0] OP_ROL  = 3'd0;
  localparam logic [2:0] OP_ROR  = 3'd1;
  localparam logic [2:0] OP_ROLC = 3'd2;
  localparam logic [2:0] OP_RORC = 3'd3;
  localparam logic [2:0] OP_SHL  = 3'd4;
  localparam logic [2:0] OP_SHR  = 3'd5;
  localparam logic [2:0] OP_SHRA = 3'd6;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t            state_reg, state_next;
  logic [2:0]        op_reg;
  logic [1:0]        size_reg;
  logic [DATA_W-1:0] a_reg;
  logic [DATA_W-1:0] w_reg, w_next;
  logic [CNT_W-1:0]  n_reg;
  logic              cy_reg, cy_next;
  logic              n_one_reg;
  logic              n_zero_reg;
  logic [DATA_W-1:0] r_reg;
  logic [5:0]        flags_reg;
  logic [5:0]        mask_reg;
  logic              done_reg;

  logic [CNT_W-1:0]  n_eff;
  logic [IDX_W-1:0]  msb_idx, in_msb_idx;
  logic [DATA_W-1:0] size_mask, in_mask;
  logic [DATA_W-1:0] r_next;
  logic [5:0]        flags_next, mask_next;

  // Size code to msb position; dword only exists in the 32-bit build,
  // everything else that is not byte behaves as word.
  function automatic logic [IDX_W-1:0] msb_of(input logic [1:0] sz);
    if (sz == 2'b00)
      return IDX_W'(7);
    else if (sz == 2'b10 && DATA_W == 32)
      return IDX_W'(DATA_W - 1);
    else
      return IDX_W'(15);
  endfunction

  assign msb_idx    = msb_of(size_reg);
  assign in_msb_idx = msb_of(bus.size);

  // Slice masks: one bit per operand bit, set when it lies inside the size.
  for (genvar gi = 0; gi < DATA_W; gi++) begin : g_mask
    assign size_mask[gi] = (int'(msb_idx) >= gi);
    assign in_mask[gi]   = (int'(in_msb_idx) >= gi);
  end

  // Reserved op collapses to a zero-step operation.
`ifdef ALU_SHIFT_COUNT_MASK_EN
  assign n_eff = (bus.op == 3'd7) ? '0 : CNT_W'(bus.count[4:0]);
`else
  assign n_eff = (bus.op == 3'd7) ? '0 : bus.count;
`endif

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      state_reg <= IDLE;
    else
      state_reg <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (bus.start) state_next = (n_eff == '0) ? DONE : SHIFT;
      SHIFT:   if (n_reg == CNT_W'(1)) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // One 1-bit step of the working slice (kept masked to the size).
  always_comb begin
    logic msb_bit;
    logic in_l;
    logic in_r;
    logic go_left;
    msb_bit = w_reg[msb_idx];
    in_l    = 1'b0;
    in_r    = 1'b0;
    go_left = 1'b0;
    case (op_reg)
      OP_ROL:  begin go_left = 1'b1; in_l = msb_bit; end
      OP_ROLC: begin go_left = 1'b1; in_l = cy_reg;  end
      OP_SHL:  begin go_left = 1'b1; in_l = 1'b0;    end
      OP_ROR:  in_r = w_reg[0];
      OP_RORC: in_r = cy_reg;
      OP_SHR:  in_r = 1'b0;
      OP_SHRA: in_r = msb_bit;
      default: ;
    endcase
    if (go_left) begin
      w_next  = ((w_reg << 1) & size_mask) | DATA_W'(in_l);
      cy_next = msb_bit;
    end else begin
      w_next  = (w_reg >> 1) | (DATA_W'(in_r) << msb_idx);
      cy_next = w_reg[0];
    end
  end

  // Result and flag values captured while in DONE.
  always_comb begin
    logic is_shift;
    logic z_f, s_f, p_f, v_f;
    is_shift = (op_reg == OP_SHL) || (op_reg == OP_SHR) || (op_reg == OP_SHRA);
    r_next   = w_reg | (a_reg & ~size_mask);
    z_f      = is_shift && (w_reg == '0);
    s_f      = is_shift && w_reg[msb_idx];
    p_f      = is_shift && ~^w_reg[7:0];
    v_f      = 1'b0;
    if (n_one_reg) begin
      case (op_reg)
        OP_ROL, OP_ROLC, OP_SHL: v_f = w_reg[msb_idx] ^ cy_reg;
        OP_ROR, OP_RORC:         v_f = w_reg[msb_idx] ^ w_reg[msb_idx - IDX_W'(1)];
        OP_SHR:                  v_f = a_reg[msb_idx];
        default:                 v_f = 1'b0;
      endcase
    end
    if (n_zero_reg) begin
      flags_next = '0;
      mask_next  = '0;
    end else begin
      flags_next = {z_f, s_f, p_f, v_f, cy_reg, 1'b0};
      mask_next  = {is_shift, is_shift, is_shift, n_one_reg, 1'b1, 1'b0};
    end
  end

  // Operand latch, stepping datapath and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_reg     <= '0;
      size_reg   <= '0;
      a_reg      <= '0;
      w_reg      <= '0;
      n_reg      <= '0;
      cy_reg     <= 1'b0;
      n_one_reg  <= 1'b0;
      n_zero_reg <= 1'b0;
      r_reg      <= '0;
      flags_reg  <= '0;
      mask_reg   <= '0;
      done_reg   <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            op_reg     <= bus.op;
            size_reg   <= bus.size;
            a_reg      <= bus.A;
            w_reg      <= bus.A & in_mask;
            n_reg      <= n_eff;
            cy_reg     <= bus.cy_in;
            n_one_reg  <= (n_eff == CNT_W'(1));
            n_zero_reg <= (n_eff == '0);
          end
        end
        SHIFT: begin
          w_reg  <= w_next;
          cy_reg <= cy_next;
          n_reg  <= n_reg - CNT_W'(1);
        end
        DONE: begin
          r_reg     <= r_next;
          flags_reg <= flags_next;
          mask_reg  <= mask_next;
          done_reg  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy       = (state_reg != IDLE);
  assign bus.done       = done_reg;
  assign bus.R          = r_reg;
  assign bus.flags      = flags_reg;
  assign bus.flags_mask = mask_reg;

endmodule

// File: tb/tb_alu_shifter.sv
// Directed bench for alu_shifter (DATA_W=16, CNT_W=8) with hand-computed results.
module tb_alu_shifter;

  logic clk = 1'b0;
  logic reset_n;
  int   total = 0;
  int   bad   = 0;
  int   lat;
  logic seen_done;

  always #5 clk = ~clk;

  alu_shifter_if #(.DATA_W(16), .CNT_W(8)) bus ();

  alu_shifter #(.DATA_W(16), .CNT_W(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pulse start for one edge, then count edges until done (bounded).
  // inj > 0 pulses a bogus start at that cycle while the op is in flight.
  task automatic run_op(input logic [2:0] op, input logic [1:0] sz, input logic [15:0] a,
                        input logic [7:0] cnt, input logic cy, input int inj, output int l);
    @(negedge clk);
    bus.op = op; bus.size = sz; bus.A = a; bus.count = cnt; bus.cy_in = cy;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    l = 999;
    for (int c = 1; c <= 400; c++) begin
      if (c == inj) begin
        bus.start = 1'b1; bus.A = 16'hFFFF; bus.op = 3'd4; bus.count = 8'd1;
      end
      @(posedge clk); #1;
      bus.start = 1'b0;
      if (bus.done) begin
        l = c;
        break;
      end
    end
    $display("op=%0d size=%0d A=%04h count=%0d cy_in=%0d -> R=%04h flags=%06b mask=%06b latency=%0d",
             op, sz, a, cnt, cy, bus.R, bus.flags, bus.flags_mask, l);
  endtask

  task automatic check_op(input string tag, input logic [15:0] r, input logic [5:0] f,
                          input logic [5:0] m, input int l_exp);
    check({tag, ".R"}, 32'(bus.R), 32'(r));
    check({tag, ".flags"}, 32'(bus.flags), 32'(f));
    check({tag, ".mask"}, 32'(bus.flags_mask), 32'(m));
    check({tag, ".latency"}, 32'(lat), 32'(l_exp));
    @(posedge clk); #1;
    check({tag, ".done_width"}, 32'(bus.done), 32'd0);
    check({tag, ".idle_after"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    bus.start = 1'b0; bus.op = '0; bus.size = '0; bus.A = '0; bus.count = '0; bus.cy_in = 1'b0;
    reset_n = 1'b0;
    #2;
    check("rst.busy", 32'(bus.busy), 32'd0);
    check("rst.done", 32'(bus.done), 32'd0);
    check("rst.R", 32'(bus.R), 32'd0);
    check("rst.flags", 32'(bus.flags), 32'd0);
    check("rst.mask", 32'(bus.flags_mask), 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;

    // ROL byte: 0x81 -> 0x03, CY=1, V=1
    run_op(3'd0, 2'b00, 16'h0081, 8'd1, 1'b0, 0, lat);
    check_op("rol_byte", 16'h0003, 6'b000110, 6'b000110, 2);

    // SHL word: 0x8001 -> 0x0002, CY=1, V=1, Z=S=P=0
    run_op(3'd4, 2'b01, 16'h8001, 8'd1, 1'b0, 0, lat);
    check_op("shl_word", 16'h0002, 6'b000110, 6'b111110, 2);

    // SHRA byte by 3: 0x80 -> 0xF0, upper byte passes through
    run_op(3'd6, 2'b00, 16'h1280, 8'd3, 1'b0, 0, lat);
    check_op("shra_byte", 16'h12F0, 6'b011000, 6'b111010, 4);

    // RORC word by 17 wraps fully; bogus start mid-operation is ignored
    run_op(3'd3, 2'b01, 16'h0001, 8'd17, 1'b0, 5, lat);
    check_op("rorc_wrap", 16'h0001, 6'b000000, 6'b000010, 18);

`ifdef ALU_SHIFT_COUNT_MASK_EN
    run_op(3'd5, 2'b01, 16'h0004, 8'd33, 1'b0, 0, lat);
    check_op("shr_cnt33", 16'h0002, 6'b000000, 6'b111110, 2);
`else
    run_op(3'd5, 2'b01, 16'h0004, 8'd33, 1'b0, 0, lat);
    check_op("shr_cnt33", 16'h0000, 6'b101000, 6'b111010, 34);
`endif

    // Reserved op completes as a zero-step pass-through
    run_op(3'd7, 2'b01, 16'h1234, 8'd5, 1'b1, 0, lat);
    check_op("op7", 16'h1234, 6'b000000, 6'b000000, 1);

    // Zero count
    run_op(3'd0, 2'b01, 16'hABCD, 8'd0, 1'b0, 0, lat);
    check_op("cnt0", 16'hABCD, 6'b000000, 6'b000000, 1);

    // ROR word: 0x0001 -> 0x8000, CY=1, V=msb^msb-1=1
    run_op(3'd1, 2'b01, 16'h0001, 8'd1, 1'b0, 0, lat);
    check_op("ror_word", 16'h8000, 6'b000110, 6'b000110, 2);

    // ROLC byte: 0x80 with cy_in=0 -> 0x00, CY=1, V=1
    run_op(3'd2, 2'b00, 16'hFF80, 8'd1, 1'b0, 0, lat);
    check_op("rolc_byte", 16'hFF00, 6'b000110, 6'b000110, 2);

    // SHL byte by 9 (past the size): slice becomes 0, last out bit 0
    run_op(3'd4, 2'b00, 16'hAB01, 8'd9, 1'b0, 0, lat);
    check_op("shl_over", 16'hAB00, 6'b101000, 6'b111010, 10);

    // SHRA word by 20: all msb
    run_op(3'd6, 2'b01, 16'h8000, 8'd20, 1'b0, 0, lat);
    check_op("shra_over", 16'hFFFF, 6'b011010, 6'b111010, 21);

    // ROL word by 16 returns the operand; CY = final bit 0
    run_op(3'd0, 2'b01, 16'h1234, 8'd16, 1'b0, 0, lat);
    check_op("rol_full", 16'h1234, 6'b000000, 6'b000010, 17);

    // size=11 behaves as word: SHR 0x8000 -> 0x4000, V=A msb
    run_op(3'd5, 2'b11, 16'h8000, 8'd1, 1'b0, 0, lat);
    check_op("shr_size3", 16'h4000, 6'b001100, 6'b111110, 2);

    // size=10 with DATA_W=16 behaves as word: SHL 0x4000 -> 0x8000
    run_op(3'd4, 2'b10, 16'h4000, 8'd1, 1'b0, 0, lat);
    check_op("shl_size2", 16'h8000, 6'b011100, 6'b111110, 2);

    // Reset in the middle of a count=10 shift
    @(negedge clk);
    bus.op = 3'd4; bus.size = 2'b01; bus.A = 16'h00FF; bus.count = 8'd10; bus.cy_in = 1'b0;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("abort.busy_before", 32'(bus.busy), 32'd1);
    reset_n = 1'b0;
    #1;
    check("abort.busy", 32'(bus.busy), 32'd0);
    check("abort.done", 32'(bus.done), 32'd0);
    check("abort.R", 32'(bus.R), 32'd0);
    check("abort.flags", 32'(bus.flags), 32'd0);
    check("abort.mask", 32'(bus.flags_mask), 32'd0);
    seen_done = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      if (bus.done) seen_done = 1'b1;
    end
    reset_n = 1'b1;
    repeat (12) begin
      @(posedge clk); #1;
      if (bus.done) seen_done = 1'b1;
    end
    check("abort.no_done", 32'(seen_done), 32'd0);
    check("abort.idle", 32'(bus.busy), 32'd0);
    $display("reset abort: done_seen=%0d busy=%0d", seen_done, bus.busy);

    // Operation after reset release completes normally
    run_op(3'd4, 2'b01, 16'h0001, 8'd1, 1'b0, 0, lat);
    check_op("post_reset", 16'h0002, 6'b000000, 6'b111110, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
